// File: rtl/wait_event_engine_if.sv
// Command/status bundle for wait_event_engine.
//   master : sequencer side; drives cmd_valid, cmd_sel, cmd_mode, cmd_value, cmd_occ,
//            cmd_timeout and abort; observes cmd_ready, busy, done, timeout, err, elapsed.
//   slave  : engine side; the mirror image of master.
interface wait_event_engine_if #(
  parameter int unsigned CH_NB     = 8,
  parameter int unsigned CH_WIDTH  = 32,
  parameter int unsigned OCC_WIDTH = 8,
  parameter int unsigned TMO_WIDTH = 32
);
  localparam int unsigned SelW = (CH_NB > 1) ? $clog2(CH_NB) : 1;

  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [SelW-1:0]      cmd_sel;
  logic [2:0]           cmd_mode;
  logic [CH_WIDTH-1:0]  cmd_value;
  logic [OCC_WIDTH-1:0] cmd_occ;
  logic [TMO_WIDTH-1:0] cmd_timeout;
  logic                 abort;
  logic                 busy;
  logic                 done;
  logic                 timeout;
  logic                 err;
  logic [TMO_WIDTH-1:0] elapsed;

  modport master (
    output cmd_valid, cmd_sel, cmd_mode, cmd_value, cmd_occ, cmd_timeout, abort,
    input  cmd_ready, busy, done, timeout, err, elapsed
  );

  modport slave (
    input  cmd_valid, cmd_sel, cmd_mode, cmd_value, cmd_occ, cmd_timeout, abort,
    output cmd_ready, busy, done, timeout, err, elapsed
  );
endinterface

// File: rtl/wait_event_engine.sv
// Command-driven multi-channel event waiter.
// A command selects one of CH_NB channels, a detection mode (RISE, FALL, HIGH, LOW, MATCH,
// CHANGE), an occurrence/stability count and an optional timeout. The engine waits, then
// pulses done or timeout for one cycle and reports the number of WAIT cycles consumed.
// Ports:
//   clk          : clock, all logic on the rising edge
//   rst_n        : synchronous active-low reset
//   wait_signals : CH_NB channels, channel c at [c*CH_WIDTH +: CH_WIDTH]
//   bus          : command/status bundle (wait_event_engine_if.slave)
// Build option: define WAIT_EVENT_TIMEOUT_EN to build the timeout comparator; without it
// cmd_timeout is ignored and the timeout output is tied low.
module wait_event_engine #(
  parameter int unsigned CH_NB     = 8,
  parameter int unsigned CH_WIDTH  = 32,
  parameter int unsigned OCC_WIDTH = 8,
  parameter int unsigned TMO_WIDTH = 32
) (
  input logic                      clk,
  input logic                      rst_n,
  input logic [CH_NB*CH_WIDTH-1:0] wait_signals,
  wait_event_engine_if.slave       bus
);

  localparam int unsigned SelW = (CH_NB > 1) ? $clog2(CH_NB) : 1;

  localparam logic [2:0] ModeRise   = 3'd0;
  localparam logic [2:0] ModeFall   = 3'd1;
  localparam logic [2:0] ModeHigh   = 3'd2;
  localparam logic [2:0] ModeLow    = 3'd3;
  localparam logic [2:0] ModeMatch  = 3'd4;
  localparam logic [2:0] ModeChange = 3'd5;

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e               state_q, state_d;
  logic [2:0]           mode_q;
  logic [SelW-1:0]      sel_q;
  logic [CH_WIDTH-1:0]  value_q;
  logic [OCC_WIDTH-1:0] target_q;
  logic [CH_WIDTH-1:0]  prev_q, prev_d;
  logic [OCC_WIDTH-1:0] occ_q, occ_d;
  logic [TMO_WIDTH-1:0] elapsed_q, elapsed_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 accept;
  logic                 illegal;
  logic                 hit;
  logic                 level;
  logic                 reached;
  logic                 tmo_hit;
  logic [OCC_WIDTH:0]   occ_inc;
  logic [TMO_WIDTH-1:0] elapsed_inc;
  logic [CH_WIDTH-1:0]  cur_wait;
  logic [CH_WIDTH-1:0]  cur_cmd;

  function automatic logic [CH_WIDTH-1:0] pick(input logic [CH_NB*CH_WIDTH-1:0] ws,
                                               input logic [SelW-1:0] s);
    logic [CH_WIDTH-1:0] r;
    r = '0;
    for (int unsigned c = 0; c < CH_NB; c++) begin
      if (32'(s) == c) r = ws[c*CH_WIDTH +: CH_WIDTH];
    end
    return r;
  endfunction

  assign cur_wait = pick(wait_signals, sel_q);
  assign cur_cmd  = pick(wait_signals, bus.cmd_sel);
  assign illegal  = (bus.cmd_mode > ModeChange) || (32'(bus.cmd_sel) >= CH_NB);
  assign accept   = (state_q == StIdle) && bus.cmd_valid && !illegal;

  // Condition of the current sample against the previous one. level marks the modes whose
  // run count must be consecutive.
  always_comb begin
    hit   = 1'b0;
    level = 1'b0;
    case (mode_q)
      ModeRise:   hit = ~prev_q[0] & cur_wait[0];
      ModeFall:   hit = prev_q[0] & ~cur_wait[0];
      ModeHigh:   begin hit = cur_wait[0];  level = 1'b1; end
      ModeLow:    begin hit = ~cur_wait[0]; level = 1'b1; end
      ModeMatch:  begin hit = (cur_wait == value_q); level = 1'b1; end
      ModeChange: hit = (cur_wait != prev_q);
      default:    hit = 1'b0;
    endcase
  end

  assign occ_inc     = {1'b0, occ_q} + {{OCC_WIDTH{1'b0}}, 1'b1};
  assign reached     = hit && (occ_inc >= {1'b0, target_q});
  assign elapsed_inc = (&elapsed_q) ? elapsed_q : elapsed_q + TMO_WIDTH'(1);

`ifdef WAIT_EVENT_TIMEOUT_EN
  logic [TMO_WIDTH-1:0] tmo_lim_q;
  logic                 timeout_q, timeout_d;

  // Compares the post-increment count so a limit of T ends the wait on the T-th sample.
  assign tmo_hit = (tmo_lim_q != '0) && (elapsed_inc == tmo_lim_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_lim_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (accept) tmo_lim_q <= bus.cmd_timeout;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign tmo_hit     = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    occ_d     = occ_q;
    elapsed_d = elapsed_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
`ifdef WAIT_EVENT_TIMEOUT_EN
    timeout_d = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          if (illegal) begin
            err_d = 1'b1;
          end else begin
            // Seed prev with the acceptance sample so an edge already present is ignored.
            prev_d    = cur_cmd;
            occ_d     = '0;
            elapsed_d = '0;
            state_d   = StWait;
          end
        end
      end
      StWait: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else begin
          elapsed_d = elapsed_inc;
          prev_d    = cur_wait;
          if (reached) begin
            // A hit beats a timeout landing on the same sample.
            occ_d   = occ_inc[OCC_WIDTH-1:0];
            done_d  = 1'b1;
            state_d = StDone;
          end else begin
            if (hit) begin
              occ_d = occ_inc[OCC_WIDTH-1:0];
            end else if (level) begin
              occ_d = '0;
            end
            if (tmo_hit) begin
`ifdef WAIT_EVENT_TIMEOUT_EN
              timeout_d = 1'b1;
`endif
              state_d   = StDone;
            end
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      prev_q    <= '0;
      occ_q     <= '0;
      elapsed_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      occ_q     <= occ_d;
      elapsed_q <= elapsed_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q   <= '0;
      sel_q    <= '0;
      value_q  <= '0;
      target_q <= '0;
    end else if (accept) begin
      mode_q   <= bus.cmd_mode;
      sel_q    <= bus.cmd_sel;
      value_q  <= bus.cmd_value;
      // A count of 0 behaves as 1.
      target_q <= (bus.cmd_occ == '0) ? OCC_WIDTH'(1) : bus.cmd_occ;
    end
  end

  assign bus.cmd_ready = (state_q == StIdle);
  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.elapsed   = elapsed_q;

endmodule

// File: tb/tb_wait_event_engine.sv
module tb_wait_event_engine;
  localparam int unsigned CH_NB     = 8;
  localparam int unsigned CH_WIDTH  = 32;
  localparam int unsigned OCC_WIDTH = 8;
  localparam int unsigned TMO_WIDTH = 32;

`ifdef WAIT_EVENT_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif

  localparam logic [2:0] MRise = 3'd0, MFall = 3'd1, MHigh = 3'd2, MLow = 3'd3,
                         MMatch = 3'd4, MChange = 3'd5;
  localparam int KNone = 0, KDone = 1, KTmo = 2, KAbort = 3, KBoth = 4;

  typedef struct {
    logic [2:0]  mode;
    logic [2:0]  sel;
    logic [31:0] value;
    logic [7:0]  occ;
    logic [31:0] tmo;
    logic [63:0] pat;      // bit i: sample i equals value (1) or ~value (0); i=0 at accept
    int          abort_at; // 0 = no abort
    int          exp_kind;
    int          exp_at;
  } vec_t;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [CH_NB*CH_WIDTH-1:0] wait_signals;
  logic [47:0]               ws6;

  int checks = 0;
  int errors = 0;

  wait_event_engine_if #(.CH_NB(CH_NB), .CH_WIDTH(CH_WIDTH), .OCC_WIDTH(OCC_WIDTH),
                         .TMO_WIDTH(TMO_WIDTH)) bus ();
  wait_event_engine #(.CH_NB(CH_NB), .CH_WIDTH(CH_WIDTH), .OCC_WIDTH(OCC_WIDTH),
                      .TMO_WIDTH(TMO_WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wait_signals(wait_signals),
    .bus         (bus)
  );

  // Non-power-of-two instance so an out-of-range channel index can be driven.
  wait_event_engine_if #(.CH_NB(6), .CH_WIDTH(8), .OCC_WIDTH(8), .TMO_WIDTH(32)) bus6 ();
  wait_event_engine #(.CH_NB(6), .CH_WIDTH(8), .OCC_WIDTH(8), .TMO_WIDTH(32)) dut6 (
    .clk         (clk),
    .rst_n       (rst_n),
    .wait_signals(ws6),
    .bus         (bus6)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] smp(input vec_t v, input int i);
    return v.pat[i] ? v.value : ~v.value;
  endfunction

  task automatic set_chan(input logic [2:0] sel, input logic [31:0] val);
    for (int c = 0; c < int'(CH_NB); c++) wait_signals[c*CH_WIDTH +: CH_WIDTH] = $urandom;
    wait_signals[sel*CH_WIDTH +: CH_WIDTH] = val;
  endtask

  // Reference: walks the sample list and applies the waiting rules directly.
  function automatic void model(input vec_t v, input int lim, output int kind, output int at);
    int          target;
    int          run;
    logic [31:0] prev, cur;
    bit          hit, lvl;
    target = (v.occ == 0) ? 1 : int'(v.occ);
    run    = 0;
    kind   = KNone;
    at     = lim;
    prev   = smp(v, 0);
    for (int i = 1; i <= lim; i++) begin
      cur = smp(v, i);
      lvl = (v.mode == MHigh) || (v.mode == MLow) || (v.mode == MMatch);
      case (v.mode)
        MRise:   hit = !prev[0] && cur[0];
        MFall:   hit = prev[0] && !cur[0];
        MHigh:   hit = cur[0];
        MLow:    hit = !cur[0];
        MMatch:  hit = (cur == v.value);
        default: hit = (cur != prev);
      endcase
      if (hit) run++;
      else if (lvl) run = 0;
      if (hit && run >= target) begin kind = KDone; at = i; return; end
      if (TmoEn && v.tmo != 0 && i == int'(v.tmo)) begin kind = KTmo; at = i; return; end
      prev = cur;
    end
  endfunction

  // Entered and left at a negedge with the engine idle.
  task automatic run_cmd(input vec_t v, input int lim, output int kind, output int at,
                         output int el);
    bus.cmd_valid   = 1'b1;
    bus.cmd_sel     = v.sel;
    bus.cmd_mode    = v.mode;
    bus.cmd_value   = v.value;
    bus.cmd_occ     = v.occ;
    bus.cmd_timeout = v.tmo;
    bus.abort       = 1'b0;
    set_chan(v.sel, smp(v, 0));
    @(negedge clk);
    chk("accept_busy", bus.busy, 1);
    chk("accept_ready", bus.cmd_ready, 0);
    kind = KNone;
    at   = lim;
    el   = 0;
    for (int i = 1; i <= lim; i++) begin
      bus.cmd_valid   = 1'($urandom);
      bus.cmd_sel     = 3'($urandom);
      bus.cmd_mode    = 3'($urandom);
      bus.cmd_value   = $urandom;
      bus.cmd_occ     = 8'($urandom);
      bus.cmd_timeout = $urandom_range(1, 5);
      set_chan(v.sel, smp(v, i));
      bus.abort = (i == v.abort_at);
      @(negedge clk);
      bus.abort = 1'b0;
      if (i == v.abort_at) begin
        kind = KAbort;
        at   = i;
        el   = int'(bus.elapsed);
        chk("abort_ready", bus.cmd_ready, 1);
        chk("abort_pulse", {bus.done, bus.timeout}, 0);
        break;
      end
      if (bus.done || bus.timeout) begin
        kind = (bus.done && bus.timeout) ? KBoth : (bus.done ? KDone : KTmo);
        at   = i;
        el   = int'(bus.elapsed);
        chk("done_cycle_ready", bus.cmd_ready, 0);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("pulse_width", {bus.done, bus.timeout}, 0);
        chk("ready_after_done", bus.cmd_ready, 1);
        chk("elapsed_hold", bus.elapsed, el);
        break;
      end
    end
    bus.cmd_valid = 1'b0;
    if (kind == KNone) begin
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      el = int'(bus.elapsed);
      chk("cleanup_ready", bus.cmd_ready, 1);
    end
  endtask

  task automatic check_result(input string tag, input int kind, input int at, input int el,
                              input int ek, input int ea);
    chk({tag, "_kind"}, kind, ek);
    chk({tag, "_cycle"}, at, ea);
    chk({tag, "_elapsed"}, el, (ek == KAbort) ? ea - 1 : ea);
  endtask

  initial begin
    vec_t vecs[$];
    vec_t v;
    int   kind, at, el, ek, ea;

    vecs.push_back('{MRise,   3'd3, 32'h1,        8'd1, 32'd0,   ~64'hF,   0, KDone, 4});
    vecs.push_back('{MFall,   3'd0, 32'h1,        8'd3, 32'd100, 64'hF7B,  0, KDone, 12});
    vecs.push_back('{MMatch,  3'd1, 32'hCAFEDECA, 8'd4, 32'd0,   64'h1EE,  0, KDone, 8});
    vecs.push_back('{MHigh,   3'd2, 32'h5,        8'd2, 32'd0,   64'h64,   0, KDone, 6});
    vecs.push_back('{MLow,    3'd4, 32'h3,        8'd0, 32'd0,   64'h7,    0, KDone, 3});
    vecs.push_back('{MChange, 3'd7, 32'h12345679, 8'd2, 32'd0,   64'h1F8,  0, KDone, 9});
    vecs.push_back('{MRise,   3'd6, 32'h1,        8'd1, 32'd0,   ~64'h60,  0, KDone, 7});
    vecs.push_back('{MMatch,  3'd5, 32'hA5A50001, 8'd1, 32'd0,   ~64'h0,   0, KDone, 1});
    vecs.push_back('{MChange, 3'd7, 32'h1,        8'd1, 32'd0,   64'h0,    5, KAbort, 5});

    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_sel = '0; bus.cmd_mode = '0; bus.cmd_value = '0;
    bus.cmd_occ = '0; bus.cmd_timeout = '0; bus.abort = 1'b0;
    bus6.cmd_valid = 1'b0; bus6.cmd_sel = '0; bus6.cmd_mode = '0; bus6.cmd_value = '0;
    bus6.cmd_occ = '0; bus6.cmd_timeout = '0; bus6.abort = 1'b0;
    wait_signals = '0;
    ws6 = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", bus.cmd_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_pulses", {bus.done, bus.timeout, bus.err}, 0);
    chk("rst_elapsed", bus.elapsed, 0);

    // Directed table; commands go back to back.
    foreach (vecs[k]) begin
      run_cmd(vecs[k], 40, kind, at, el);
      check_result($sformatf("vec%0d", k), kind, at, el, vecs[k].exp_kind, vecs[k].exp_at);
    end

    // HIGH with timeout 10 and the bit held low.
    v = '{MHigh, 3'd2, 32'h1, 8'd1, 32'd10, 64'h0, 0, 0, 0};
    run_cmd(v, 50, kind, at, el);
    check_result("tmo_stall", kind, at, el, TmoEn ? KTmo : KNone, TmoEn ? 10 : 50);
    // Same, but the bit rises on the timeout sample: hit wins.
    v.pat = ~64'h3FF;
    run_cmd(v, 50, kind, at, el);
    check_result("tmo_tie", kind, at, el, KDone, 10);

    // Illegal modes.
    for (int m = 6; m < 8; m++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_mode  = 3'(m);
      bus.cmd_sel   = 3'd0;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      chk($sformatf("err_mode%0d", m), bus.err, 1);
      chk($sformatf("err_mode%0d_busy", m), bus.busy, 0);
      @(negedge clk);
      chk($sformatf("err_mode%0d_clear", m), bus.err, 0);
    end

    // Out-of-range channel on the six-channel instance, then a legal MATCH on channel 5.
    ws6 = 48'h3C_00_00_00_00_00;
    for (int s = 6; s < 8; s++) begin
      bus6.cmd_valid = 1'b1;
      bus6.cmd_mode  = MMatch;
      bus6.cmd_sel   = 3'(s);
      bus6.cmd_value = 8'h3C;
      bus6.cmd_occ   = 8'd1;
      @(negedge clk);
      bus6.cmd_valid = 1'b0;
      chk($sformatf("err_sel%0d", s), bus6.err, 1);
      chk($sformatf("err_sel%0d_busy", s), bus6.busy, 0);
      @(negedge clk);
    end
    bus6.cmd_valid = 1'b1;
    bus6.cmd_sel   = 3'd5;
    @(negedge clk);
    bus6.cmd_valid = 1'b0;
    chk("ch6_busy", bus6.busy, 1);
    chk("ch6_err", bus6.err, 0);
    @(negedge clk);
    chk("ch6_done", bus6.done, 1);
    chk("ch6_elapsed", bus6.elapsed, 1);
    @(negedge clk);

    // Reset in the middle of a wait.
    bus.cmd_valid = 1'b1; bus.cmd_sel = 3'd7; bus.cmd_mode = MChange; bus.cmd_occ = 8'd1;
    bus.cmd_timeout = 32'd0;
    set_chan(3'd7, 32'h0);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (3) begin set_chan(3'd7, 32'h0); @(negedge clk); end
    chk("midwait_elapsed", bus.elapsed, 3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_ready", bus.cmd_ready, 1);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_pulses", {bus.done, bus.timeout, bus.err}, 0);
    chk("midrst_elapsed", bus.elapsed, 0);
    @(negedge clk);
    chk("midrst_stay_idle", bus.busy, 0);

    // Random commands against the reference model.
    for (int n = 0; n < 40; n++) begin
      v.mode     = 3'($urandom_range(0, 5));
      v.sel      = 3'($urandom_range(0, 7));
      v.value    = $urandom | 32'h1;
      v.occ      = 8'($urandom_range(0, 4));
      v.tmo      = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 30));
      v.pat      = {$urandom, $urandom};
      v.abort_at = 0;
      model(v, 60, ek, ea);
      run_cmd(v, 60, kind, at, el);
      check_result($sformatf("rnd%0d", n), kind, at, el, ek, ea);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wait_event_engine.md
# wait_event_engine

Parametrised multi-channel event waiter for the generic HDL testbench. It replaces the single-bit, single-mode wait-event wrapper with a command-driven engine. The sequencer selects one of CH_NB monitored buses, a detection mode, an occurrence or stability count and an optional timeout. It then receives a one-cycle completion or timeout pulse, plus the elapsed cycle count. The engine sits between the testbench sequencer class and the DUT signals aliased into the wait-event interface.

## Interface
- CH_NB, 8: number of monitored channels (≥2)
- CH_WIDTH, 32: width of each channel
- OCC_WIDTH, 8: width of the occurrence/stability count
- TMO_WIDTH, 32: width of the timeout and elapsed counters
- clk  in  1  testbench clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- wait_signals  in  CH_NB*CH_WIDTH  channel c occupies bits [c*CH_WIDTH +: CH_WIDTH]
- cmd_valid  in  1  command request
- cmd_ready  out  1  high in IDLE only
- cmd_sel  in  $clog2(CH_NB)  channel index
- cmd_mode  in  3  0 RISE, 1 FALL, 2 HIGH, 3 LOW, 4 MATCH, 5 CHANGE
- cmd_value  in  CH_WIDTH  compare value for MATCH
- cmd_occ  in  OCC_WIDTH  edge count (RISE/FALL/CHANGE) or consecutive-cycle count (HIGH/LOW/MATCH); 0 treated as 1
- cmd_timeout  in  TMO_WIDTH  max WAIT cycles; 0 = infinite
- abort  in  1  cancel current wait
- busy  out  1  high in WAIT and DONE
- done  out  1  one-cycle pulse, event satisfied
- timeout  out  1  one-cycle pulse, timeout expired
- err  out  1  one-cycle pulse, illegal command
- elapsed  out  TMO_WIDTH  WAIT cycles consumed by the last command

## Operation
- Decoding of cmd_sel:
  - RISE/FALL/HIGH/LOW use bit 0 of the selected channel.
  - MATCH compares the full channel against cmd_value.
  - CHANGE fires on any difference between the current and previous sample.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - On cmd_valid && cmd_ready, latch all cmd_* fields.
  - Load the prev-sample register with the current selected channel value.
  - Clear the occ and elapsed counters, then go to WAIT.
  - If cmd_mode > 5 or cmd_sel ≥ CH_NB, do not go to WAIT. Instead pulse err in the next cycle and stay in IDLE.
- WAIT, each cycle:
  - Increment elapsed, saturating at all-ones.
  - Evaluate the condition on the current sample against prev, then update prev.
  - Edge modes: each hit increments occ.
  - Level and MATCH modes: occ increments on each true cycle and clears to 0 on any false cycle.
  - When occ+hit reaches max(cmd_occ,1), go to DONE with done flagged.
  - If the condition is not met and elapsed == cmd_timeout (cmd_timeout ≠ 0), go to DONE with timeout flagged.
  - Hit and timeout in the same cycle: hit wins, and only done pulses.
  - abort: go to IDLE next cycle, no pulse; elapsed holds its value.
- DONE: lasts exactly one cycle.
  - done or timeout is high and cmd_ready is low.
  - Next state is IDLE.
- abort in IDLE or DONE is ignored.
- cmd_* fields are don't-care while cmd_ready is low.
- elapsed holds from DONE until the next command acceptance.

## Timing
- Reset values:
  - State is IDLE, so cmd_ready = 1.
  - busy, done, timeout and err are 0.
  - elapsed and all internal counters are 0.
- rst_n low during WAIT: IDLE on the next edge, no pulse.
- Accept edge at cycle N; the first evaluated sample is at edge N+1. An edge present at acceptance is never counted.
- Hit sampled at edge k: done is high in cycle k+1, and cmd_ready is high in cycle k+2.
- Back-to-back commands: a new command may be accepted in the first IDLE cycle after DONE.
- With cmd_timeout = T and no hit: timeout is high in cycle N+T+1, and elapsed = T.

## Configuration
- WAIT_EVENT_TIMEOUT_EN defined:
  - The timeout comparator is built.
  - cmd_timeout and the timeout output behave as above.
- Not defined:
  - The comparator is removed and cmd_timeout is ignored.
  - The timeout output is tied to 0.
  - Waits end only on a hit or abort.
  - elapsed still counts, saturating.

## Test plan
- RISE, ch 3, occ 1, timeout 0. Bit 0 goes 0→1 four cycles after accept → done one cycle later, elapsed = 4, cmd_ready high the cycle after.
- FALL, ch 0, occ 3, timeout 100. Three falling edges spaced 5 cycles apart, first at cycle 2 → done after the third edge, elapsed = 12.
- MATCH 0xCAFEDECA, occ 4, ch 1. Value held 3 cycles, dropped 1, then held 4 → done at the 8th evaluated cycle only.
- HIGH, timeout 10, bit held 0 → timeout pulse, elapsed = 10, no done. Rerun with the bit rising exactly at cycle 10 → done only.
- CHANGE, ch 7. abort at cycle 5 → IDLE next cycle, no pulse. A reset asserted mid-WAIT on a second command → all outputs return to reset values.
- Illegal commands: cmd_mode = 6 → err pulse, no busy. cmd_sel = CH_NB (when CH_NB is not a power of 2) → err. Without WAIT_EVENT_TIMEOUT_EN, a timeout-10 stalled wait shows no timeout after 50 cycles.
